// File: rtl/decim_recorder_pkg.sv
// Shared audio definitions for the decimating recorder: state encodings,
// default geometry, the sample scaling shift and the 18->8 bit saturator.
package decim_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } recState_t;

  localparam int DEFAULT_DECIM      = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 12;
  localparam int SAMPLE_SHIFT       = 10;
  localparam int IN_W               = 18;
  localparam int OUT_W              = 8;
  localparam int PHASE_W            = 3;

  // Scale the filtered sample down to 8 bits and clamp it into the signed
  // 8-bit range instead of letting the upper bits wrap.
  function automatic logic signed [OUT_W-1:0] sat8(input logic signed [IN_W-1:0] y);
    logic signed [IN_W-1:0] shifted;
    shifted = y >>> SAMPLE_SHIFT;
    if (shifted > 18'sd127) begin
      return 8'sd127;
    end else if (shifted < -18'sd128) begin
      return -8'sd128;
    end else begin
      return shifted[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/decim_recorder_sample_ram.sv
// Sample buffer: synchronous write, registered read, no reset so that it
// maps onto a single block RAM.
module decim_recorder_sample_ram
  import decim_recorder_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W = OUT_W
) (
  input  logic              i_clock,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdData;

  // Write port and registered read port share the clock; contents survive reset.
  always_ff @(posedge i_clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/decim_recorder.sv
// Decimating recorder: in RECORD keeps one of every DECIM filtered samples
// (scaled to 8 bits) in a 4096-entry buffer; in PLAY emits each stored
// sample followed by DECIM-1 zeros, one value per ready strobe.
module decim_recorder
  import decim_recorder_pkg::*;
#(
  parameter int DECIM      = DEFAULT_DECIM,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic                    record,
  input  logic                    playback,
  input  logic signed [IN_W-1:0]  y_in,
  output logic signed [OUT_W-1:0] x_out,
  output logic [1:0]              state,
  output logic                    full,
  output logic [DEPTH_LOG2-1:0]   length
);

  // Read pointer carries one extra bit so a full buffer's 4096th read can be
  // told apart from the first one.
  localparam int RD_W = DEPTH_LOG2 + 1;

  recState_t                r_state;
  logic [PHASE_W-1:0]       r_phase;
  logic [DEPTH_LOG2-1:0]    r_wrAddr;
  logic [RD_W-1:0]          r_rdAddr;
  logic                     r_full;
  logic                     r_recArmed;
  logic signed [OUT_W-1:0]  r_xOut;

  recState_t                w_nextState;
  logic [RD_W-1:0]          w_rdAddrNext;
  logic [RD_W-1:0]          w_storedCount;
  logic [PHASE_W-1:0]       w_phaseLast;
  logic                     w_slot0;
  logic                     w_lastWrite;
  logic                     w_playDone;
  logic                     w_wrEn;
  logic [OUT_W-1:0]         w_wrData;
  logic [OUT_W-1:0]         w_ramQ;

  assign w_phaseLast   = PHASE_W'(DECIM - 1);
  assign w_slot0       = ready && (r_phase == '0);
  assign w_lastWrite   = (r_wrAddr == '1);
  assign w_storedCount = r_full ? {1'b1, {DEPTH_LOG2{1'b0}}} : {1'b0, r_wrAddr};
  assign w_playDone    = (r_rdAddr == w_storedCount);
  assign w_wrEn        = (r_state == ST_RECORD) && w_slot0;
  assign w_wrData      = sat8(y_in);

  // Next-state decision; record outranks playback, and PLAY must pass
  // through IDLE before a new recording can start.  After a recording stops
  // because the buffer filled, record has to be released before it re-arms,
  // otherwise a held record level would immediately wipe the full buffer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (record && r_recArmed) begin
          w_nextState = ST_RECORD;
        end else if (playback && !record && ((r_wrAddr != '0) || r_full)) begin
          w_nextState = ST_PLAY;
        end
      end
      ST_RECORD: begin
        if (!record || (w_wrEn && w_lastWrite)) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (!playback || (w_slot0 && w_playDone)) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Read pointer next value; it also addresses the RAM so the registered
  // read data always equals buffer[r_rdAddr] by the time a ready arrives.
  always_comb begin
    w_rdAddrNext = r_rdAddr;
    if ((r_state == ST_IDLE) && (w_nextState == ST_PLAY)) begin
      w_rdAddrNext = '0;
    end else if ((r_state == ST_PLAY) && w_slot0 && !w_playDone) begin
      w_rdAddrNext = r_rdAddr + RD_W'(1);
    end
  end

  decim_recorder_sample_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (OUT_W)
  ) u_sampleRam (
    .i_clock  (clock),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_wrAddr),
    .i_wrData (w_wrData),
    .i_rdAddr (w_rdAddrNext[DEPTH_LOG2-1:0]),
    .o_rdData (w_ramQ)
  );

  // FSM, phase counter, write/read pointers and the registered playback
  // output.  A ready on a state-change edge is handled by the old state;
  // x_out is forced to zero whenever the machine is not staying in PLAY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_wrAddr   <= '0;
      r_rdAddr   <= '0;
      r_full     <= 1'b0;
      r_recArmed <= 1'b1;
      r_xOut     <= '0;
    end else begin
      r_state  <= w_nextState;
      r_rdAddr <= w_rdAddrNext;

      if (w_nextState != r_state) begin
        r_phase <= '0;
      end else if (ready) begin
        r_phase <= (r_phase == w_phaseLast) ? '0 : r_phase + PHASE_W'(1);
      end

      if ((r_state == ST_IDLE) && (w_nextState == ST_RECORD)) begin
        r_wrAddr <= '0;
        r_full   <= 1'b0;
      end else if (w_wrEn) begin
        if (w_lastWrite) begin
          r_full <= 1'b1;
        end else begin
          r_wrAddr <= r_wrAddr + DEPTH_LOG2'(1);
        end
      end

      if (!record) begin
        r_recArmed <= 1'b1;
      end else if (w_wrEn && w_lastWrite) begin
        r_recArmed <= 1'b0;
      end

      if ((r_state == ST_PLAY) && (w_nextState == ST_PLAY)) begin
        if (w_slot0) begin
          r_xOut <= w_ramQ;
        end else if (ready) begin
          r_xOut <= '0;
        end
      end else begin
        r_xOut <= '0;
      end
    end
  end

  assign x_out  = r_xOut;
  assign state  = r_state;
  assign full   = r_full;
  assign length = r_wrAddr;

endmodule

// File: tb/tb_decim_recorder.sv
// Self-checking bench for decim_recorder.  The reference model keeps the
// recording as a queue of scaled samples and predicts every playback value
// from its position in the zero-stuffed stream.
module tb_decim_recorder;

  localparam int TB_DECIM = 8;
  localparam int TB_DEPTH = 4096;

  logic               clock;
  logic               reset;
  logic               ready;
  logic               record;
  logic               playback;
  logic signed [17:0] y_in;
  logic signed [7:0]  x_out;
  logic [1:0]         state;
  logic               full;
  logic [11:0]        length;

  int compared;
  int mismatched;
  int stored[$];
  int stimQ[$];
  int holdX;

  decim_recorder #(
    .DECIM      (TB_DECIM),
    .DEPTH_LOG2 (12)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .record   (record),
    .playback (playback),
    .y_in     (y_in),
    .x_out    (x_out),
    .state    (state),
    .full     (full),
    .length   (length)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the model and count the result.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference scaling: floor(y / 1024) clamped to the signed 8-bit range.
  function automatic int modelSat(input int y);
    int q;
    q = y / 1024;
    if ((y < 0) && (q * 1024 != y)) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int randSample();
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  // Drive one clock of inputs and return #1 after the edge that took them.
  task automatic applyStimulus(input logic rdy, input int yv);
    ready = rdy;
    y_in  = 18'(yv);
    @(posedge clock);
    #1;
    ready = 1'b0;
  endtask

  // Record every value in stimQ as one ready each, with gap idle clocks after each.
  task automatic recordSession(input int gap);
    record = 1'b1;
    applyStimulus(1'b0, 0);
    checkOutput("recEnter", int'(state), 1);
    stored.delete();
    for (int i = 0; i < stimQ.size(); i++) begin
      applyStimulus(1'b1, stimQ[i]);
      if (i % TB_DECIM == 0) stored.push_back(modelSat(stimQ[i]));
      checkOutput("recX", int'(x_out), 0);
      repeat (gap) applyStimulus(1'b0, stimQ[i]);
    end
    record = 1'b0;
    applyStimulus(1'b0, 0);
    checkOutput("recLen", int'(length), stored.size());
    checkOutput("recIdle", int'(state), 0);
  endtask

  // Play back the whole model recording and check each zero-stuffed output.
  task automatic playSession(input int gap);
    int expX;
    playback = 1'b1;
    applyStimulus(1'b0, 0);
    checkOutput("playEnter", int'(state), 2);
    for (int j = 0; j < stored.size() * TB_DECIM; j++) begin
      applyStimulus(1'b1, randSample());
      expX = (j % TB_DECIM == 0) ? stored[j / TB_DECIM] : 0;
      checkOutput("playX", int'(x_out), expX);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 0);
        checkOutput("playHold", int'(x_out), expX);
      end
    end
    checkOutput("playLast", int'(state), 2);
    applyStimulus(1'b1, 0);
    checkOutput("playEnd", int'(state), 0);
    checkOutput("playEndX", int'(x_out), 0);
    playback = 1'b0;
    applyStimulus(1'b0, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    ready      = 1'b0;
    record     = 1'b0;
    playback   = 1'b0;
    y_in       = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstState", int'(state), 0);
    checkOutput("rstX", int'(x_out), 0);
    checkOutput("rstLen", int'(length), 0);
    checkOutput("rstFull", int'(full), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Nothing recorded yet: playback must be refused.
    playback = 1'b1;
    repeat (3) applyStimulus(1'b1, 0);
    checkOutput("emptyPlay", int'(state), 0);
    playback = 1'b0;
    applyStimulus(1'b0, 0);

    // Ramp covering the full 18-bit input range.
    $display("[TB] ramp record/playback");
    stimQ.delete();
    for (int n = 0; n < 256; n++) stimQ.push_back((n - 128) * 1024);
    recordSession(1);
    checkOutput("rampLen", int'(length), 32);
    playSession(1);

    // Saturation extremes and a plain scaled value, then back-to-back playback.
    $display("[TB] saturation");
    stimQ.delete();
    for (int n = 0; n < 24; n++) stimQ.push_back(randSample());
    stimQ[0]  = 131071;
    stimQ[8]  = -131072;
    stimQ[16] = 5120;
    recordSession(0);
    playSession(0);

    // Three-sample recording 5, -3, 7 with continuous readies.
    $display("[TB] three-sample playback");
    stimQ.delete();
    for (int n = 0; n < 24; n++) stimQ.push_back(randSample());
    stimQ[0]  = 5 * 1024 + 300;
    stimQ[8]  = -3 * 1024;
    stimQ[16] = 7 * 1024 + 1023;
    recordSession(2);
    playSession(0);

    // Randomized sessions with varying lengths and ready spacing.
    $display("[TB] random sessions");
    for (int r = 0; r < 3; r++) begin
      stimQ.delete();
      for (int n = 0; n < int'($urandom_range(200, 1)); n++) stimQ.push_back(randSample());
      recordSession(int'($urandom_range(3, 0)));
      playSession(int'($urandom_range(3, 0)));
    end

    // Asynchronous reset in the middle of playback.
    $display("[TB] reset mid-play");
    playback = 1'b1;
    applyStimulus(1'b0, 0);
    for (int j = 0; j < 9; j++) applyStimulus(1'b1, 0);
    checkOutput("midPlayX", int'(x_out), (stored.size() > 1) ? stored[1] : 0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncState", int'(state), 0);
    checkOutput("asyncX", int'(x_out), 0);
    checkOutput("asyncLen", int'(length), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int j = 0; j < 10; j++) applyStimulus(1'b1, 0);
    checkOutput("postRstPlay", int'(state), 0);
    playback = 1'b0;
    applyStimulus(1'b0, 0);

    // record and playback together: record wins, then play follows on release.
    $display("[TB] priority and record during play");
    stimQ.delete();
    for (int n = 0; n < 40; n++) stimQ.push_back(randSample());
    playback = 1'b1;
    recordSession(0);
    applyStimulus(1'b0, 0);
    checkOutput("autoPlay", int'(state), 2);
    for (int j = 0; j < 3; j++) applyStimulus(1'b1, 0);
    record = 1'b1;
    for (int j = 3; j < 12; j++) begin
      applyStimulus(1'b1, 0);
      checkOutput("recInPlayX", int'(x_out), (j % TB_DECIM == 0) ? stored[j / TB_DECIM] : 0);
    end
    checkOutput("recInPlay", int'(state), 2);
    playback = 1'b0;
    applyStimulus(1'b0, 0);
    checkOutput("playRelease", int'(state), 0);
    applyStimulus(1'b0, 0);
    checkOutput("recAfterPlay", int'(state), 1);
    checkOutput("recAfterLen", int'(length), 0);
    record = 1'b0;
    applyStimulus(1'b0, 0);
    stored.delete();
    playback = 1'b1;
    repeat (3) applyStimulus(1'b1, 0);
    checkOutput("zeroLenPlay", int'(state), 0);
    playback = 1'b0;
    applyStimulus(1'b0, 0);

    // Fill the buffer with record held continuously.
    $display("[TB] fill buffer");
    record = 1'b1;
    applyStimulus(1'b0, 0);
    checkOutput("fillEnter", int'(state), 1);
    stored.delete();
    for (int i = 0; i <= 32760; i++) begin
      stimQ.delete();
      stimQ.push_back(randSample());
      applyStimulus(1'b1, stimQ[0]);
      if (i % TB_DECIM == 0) stored.push_back(modelSat(stimQ[0]));
      if (i == 32752) begin
        checkOutput("preFullLen", int'(length), 4095);
        checkOutput("preFullFlag", int'(full), 0);
        checkOutput("preFullState", int'(state), 1);
      end
    end
    checkOutput("fullFlag", int'(full), 1);
    checkOutput("fullState", int'(state), 0);
    checkOutput("fullLen", int'(length), 4095);
    checkOutput("fullWrites", stored.size(), TB_DEPTH);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, randSample());
    checkOutput("fullHoldState", int'(state), 0);
    checkOutput("fullHoldFlag", int'(full), 1);
    checkOutput("fullHoldLen", int'(length), 4095);
    record = 1'b0;
    applyStimulus(1'b0, 0);
    playSession(0);

    // A new recording clears the full flag.
    stimQ.delete();
    for (int n = 0; n < 9; n++) stimQ.push_back(randSample());
    recordSession(0);
    checkOutput("fullCleared", int'(full), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
